// File: rtl/rob_commit_ctrl.sv
// In-order reorder buffer: allocates tags at issue, captures CDB results, retires head in program order.
// Latency: issue-to-commit minimum 2 edges; CDB capture at edge c gives commit during cycle c+1 (no bypass).
// Backpressure: issue_ready drops when all entries are occupied; a same-cycle commit does not free a slot early.
module rob_commit_ctrl #(
    parameter int ROB_WIDTH = 3,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_req,
    input  logic [REG_WIDTH-1:0] issue_r0,
    output logic                 issue_ready,
    output logic [ROB_WIDTH-1:0] issue_tag,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_data,
    output logic                 commit,
    output logic [ROB_WIDTH-1:0] commit_tag,
    output logic [31:0]          commit_data,
    output logic [REG_WIDTH-1:0] commit_r0,
    output logic [ROB_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH + 1)'(DEPTH);

    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     done;
    logic [REG_WIDTH-1:0] r0_mem   [DEPTH];
    logic [31:0]          data_mem [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;

    logic do_issue;
    logic do_cdb;

    // Full/empty is decided by count alone, since head == tail in both cases.
    assign issue_ready = (count != FULL_CNT);
    assign issue_tag   = tail;
    assign do_issue    = issue_req && issue_ready;

    // Late or stale broadcasts (free slot, or result already captured) must not disturb an entry.
    assign do_cdb      = cdb_valid && busy[cdb_tag] && !done[cdb_tag];

    // The head entry is presented every cycle; commit qualifies it.
    assign commit      = busy[head] && done[head];
    assign commit_tag  = head;
    assign commit_data = data_mem[head];
    assign commit_r0   = r0_mem[head];

    // Control state: pointers, occupancy and per-entry flags. Issue, capture and retire never
    // target the same slot in one cycle (tail slot is free, head slot is already done), so the
    // three updates are independent.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
        end else begin
            if (commit) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + ROB_WIDTH'(1);
            end
            if (do_cdb) begin
                done[cdb_tag] <= 1'b1;
            end
            if (do_issue) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + ROB_WIDTH'(1);
            end
            count <= count + {{ROB_WIDTH{1'b0}}, do_issue} - {{ROB_WIDTH{1'b0}}, commit};
        end
    end

    // Payload storage carries no reset; it is only observed once busy/done say it is valid.
    always_ff @(posedge clk) begin
        if (do_issue) begin
            r0_mem[tail] <= issue_r0;
        end
        if (do_cdb) begin
            data_mem[cdb_tag] <= cdb_data;
        end
    end

endmodule

// File: doc/rob_commit_ctrl.md
# rob_commit_ctrl

In-order reorder-buffer controller that sequences writes into the renamed register file. It allocates ROB tags at issue and captures results broadcast on the CDB. It retires entries strictly in program order, driving the register file's `commit`, `commit_tag` and `commit_data` inputs. It sits between the issue stage, the CDB and the register file, and it is the only source of commit strobes.

## Interface
- `ROB_WIDTH`, default 3: tag width; the buffer holds 2**ROB_WIDTH entries.
- `REG_WIDTH`, default 5: architectural register index width.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high; sampled on posedge clk.
- `issue_req` in 1: issue stage requests allocation for one instruction this cycle.
- `issue_r0` in REG_WIDTH: destination register of the issuing instruction (informational, stored per entry).
- `issue_ready` out 1: buffer not full; allocation happens iff `issue_req && issue_ready`.
- `issue_tag` out ROB_WIDTH: tag granted to the current issue (equals the tail pointer).
- `cdb_valid` in 1: result broadcast this cycle.
- `cdb_tag` in ROB_WIDTH: tag of the broadcast result.
- `cdb_data` in 32: broadcast result value.
- `commit` out 1: head entry retires this cycle.
- `commit_tag` out ROB_WIDTH: tag of the retiring entry (the head pointer).
- `commit_data` out 32: result value of the retiring entry.
- `commit_r0` out REG_WIDTH: destination register of the retiring entry.
- `count` out ROB_WIDTH+1: number of occupied entries, 0 to 2**ROB_WIDTH.

## Operation
- Storage is a circular buffer of 2**ROB_WIDTH entries. Each entry holds `busy`, `done`, `r0` and `data[31:0]`.
- Pointers `head` and `tail` are ROB_WIDTH bits wide and wrap naturally modulo 2**ROB_WIDTH. `count` disambiguates full from empty.
- `issue_ready = (count != 2**ROB_WIDTH)`. It does not account for a same-cycle commit; this is deliberately conservative.
- `issue_tag = tail`, driven combinationally in every cycle, including cycles without a request.
- Allocate (`issue_req && issue_ready`): the entry at `tail` becomes `busy=1`, `done=0`, `r0=issue_r0`; `tail` increments.
- `issue_req` while full: ignored; no state changes.
- CDB capture (`cdb_valid`): if the entry at `cdb_tag` has `busy=1` and `done=0`, its `data` is set to `cdb_data` and `done` is set to 1.
  - A broadcast to a non-busy or already-done entry is ignored; data is not overwritten.
- Commit, combinational: `commit = busy[head] && done[head]`. Then `commit_tag=head`, `commit_data=data[head]` and `commit_r0=r0[head]`.
  - When `commit=0`, the other commit outputs still reflect the head entry; consumers qualify them with `commit`.
- On a posedge with `commit=1`: `busy[head]` and `done[head]` clear, and `head` increments.
- At most one issue, one CDB capture and one commit per cycle. All three may occur in the same cycle. Next `count = count + issued − committed`.
- Same-cycle issue into the slot being retired is impossible, because a full buffer blocks issue.
- A CDB capture to the head entry sets `done` at the edge; commit then asserts in the following cycle. There is no bypass from CDB to commit.
- Reset: `head=0`, `tail=0`, `count=0`, all `busy` and `done` cleared. `data` and `r0` are don't-care.
  - Reset mid-operation discards all in-flight entries. Reset dominates issue, CDB and commit in the same cycle.

## Timing
- Reset values: `commit=0`, `count=0`, `issue_ready=1`, `issue_tag=0`, `commit_tag=0`. `commit_data` and `commit_r0` are don't-care while `commit=0`.
- Issue accepted at edge t: the tag is visible on `issue_tag` during cycle t−1/t; the entry is busy from t; `issue_tag` advances at t.
- CDB at cycle c, captured at edge c: if that entry is the head, `commit=1` during cycle c+1; the register file samples it at edge c+1, where `head` advances.
- Minimum latency from issue to commit is 2 edges after issue: issue at edge t, CDB in cycle t, commit sampled at edge t+2.
- Steady-state throughput: one commit per cycle when consecutive head entries are done.
- `commit` stays high across consecutive cycles while successive head entries are done.

## Test plan
- Reset, then idle: `commit=0`, `count=0`, `issue_ready=1`, `issue_tag=0`, held for 10 cycles.
- Issue tags 0, 1, 2; CDB tag 2 = 0xC, tag 0 = 0xA, tag 1 = 0xB in that order -> commits in order tag 0 = 0xA, then tags 1 = 0xB and 2 = 0xC on back-to-back cycles, then `count=0`.
- Issue 8 with no CDB -> `count=8`, `issue_ready=0`. A 9th `issue_req` is ignored (`tail` and `count` unchanged). CDB tag 0, then one commit -> `issue_ready=1` the cycle after the commit edge.
- Wrap-around: run 20 instructions through with steady issue and CDB -> tags cycle 0..7,0..; commit order and data match issue order; no lost or duplicated commit.
- Simultaneous: `count=3`, head done; in one cycle issue, CDB for entry head+1 and commit -> `count` stays 3, head+1 commits the next cycle. A CDB to a non-busy tag leaves state unchanged.
- Reset asserted with 5 in-flight entries and a concurrent CDB -> next cycle `count=0`, `commit=0`, `issue_tag=0`; a late CDB for old tag 3 is ignored.
